// File: rtl/mac_isa.sv
// ----------------------------------------------------------------------------
// mac_isa : single-cycle instruction-driven 16-bit multiply-accumulate unit
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module mac_isa (
  input  logic        Clk,
  input  logic        rst,
  input  logic        en,
  input  logic [31:0] Inputs,
  output logic [7:0]  Control_out
);

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_CLR = 4'h1;
  localparam logic [3:0] OP_MUL = 4'h2;
  localparam logic [3:0] OP_MAC = 4'h3;
  localparam logic [3:0] OP_ADD = 4'h4;
  localparam logic [3:0] OP_SUB = 4'h5;
  localparam logic [3:0] OP_SHR = 4'h6;
  localparam logic [3:0] OP_SHL = 4'h7;
  localparam logic [3:0] OP_AND = 4'h8;
  localparam logic [3:0] OP_OR  = 4'h9;
  localparam logic [3:0] OP_XOR = 4'hA;

  localparam logic [1:0] SEL_LO   = 2'b00;
  localparam logic [1:0] SEL_HI   = 2'b01;
  localparam logic [1:0] SEL_STAT = 2'b10;

  logic [3:0]  w_op;
  logic [1:0]  w_sel;
  logic [7:0]  w_a;
  logic [7:0]  w_b;
  logic [15:0] w_imm;
  logic [15:0] w_prod;
  logic [16:0] w_mac_sum;
  logic [16:0] w_add_sum;
  logic        w_borrow;

  logic [15:0] acc_q, acc_d;
  logic        z_q, z_d;
  logic        n_q, n_d;
  logic        v_q, v_d;
  logic        ill_q, ill_d;
  logic [3:0]  last_op_q, last_op_d;
  logic [7:0]  ctrl_q, ctrl_d;

  assign w_op      = Inputs[31:28];
  assign w_sel     = Inputs[25:24];
  assign w_a       = Inputs[15:8];
  assign w_b       = Inputs[7:0];
  assign w_imm     = Inputs[15:0];
  assign w_prod    = 16'(w_a) * 16'(w_b);
  assign w_mac_sum = {1'b0, acc_q} + {1'b0, w_prod};
  assign w_add_sum = {1'b0, acc_q} + {1'b0, w_imm};
  assign w_borrow  = (w_imm > acc_q);

  always_comb begin
    acc_d     = acc_q;
    v_d       = v_q;
    ill_d     = ill_q;
    last_op_d = last_op_q;
    z_d       = z_q;
    n_d       = n_q;
    if (en) begin
      ill_d     = 1'b0;
      last_op_d = w_op;
      case (w_op)
        OP_NOP: acc_d = acc_q;
        OP_CLR: begin
          acc_d = 16'h0000;
          v_d   = 1'b0;
        end
        OP_MUL: acc_d = w_prod;
        OP_MAC: begin
          acc_d = w_mac_sum[15:0];
          v_d   = v_q | w_mac_sum[16];
        end
        OP_ADD: begin
          acc_d = w_add_sum[15:0];
          v_d   = v_q | w_add_sum[16];
        end
        OP_SUB: begin
          acc_d = acc_q - w_imm;
          v_d   = v_q | w_borrow;
        end
        OP_SHR: acc_d = acc_q >> w_b[3:0];
        OP_SHL: acc_d = acc_q << w_b[3:0];
        OP_AND: acc_d = acc_q & w_imm;
        OP_OR:  acc_d = acc_q | w_imm;
        OP_XOR: acc_d = acc_q ^ w_imm;
        default: begin
          acc_d = acc_q;
          ill_d = 1'b1;
        end
      endcase
      z_d = (acc_d == 16'h0000);
      n_d = acc_d[15];
    end
  end

  // Output byte is built from the post-edge state so it shows this instruction's effect.
  always_comb begin
    ctrl_d = ctrl_q;
    if (en) begin
      case (w_sel)
        SEL_LO:   ctrl_d = acc_d[7:0];
        SEL_HI:   ctrl_d = acc_d[15:8];
        SEL_STAT: ctrl_d = {z_d, n_d, v_d, ill_d, last_op_d};
        default:  ctrl_d = 8'h00;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (!rst) begin
      acc_q     <= 16'h0000;
      z_q       <= 1'b0;
      n_q       <= 1'b0;
      v_q       <= 1'b0;
      ill_q     <= 1'b0;
      last_op_q <= 4'h0;
      ctrl_q    <= 8'h00;
    end else begin
      acc_q     <= acc_d;
      z_q       <= z_d;
      n_q       <= n_d;
      v_q       <= v_d;
      ill_q     <= ill_d;
      last_op_q <= last_op_d;
      ctrl_q    <= ctrl_d;
    end
  end

  assign Control_out = ctrl_q;

endmodule

`default_nettype wire

// File: tb/tb_mac_isa.sv
// ----------------------------------------------------------------------------
// tb_mac_isa : directed self-checking bench for mac_isa
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module tb_mac_isa;

  logic        Clk;
  logic        rst;
  logic        en;
  logic [31:0] Inputs;
  logic [7:0]  Control_out;

  int tests_run;
  int tests_failed;

  mac_isa dut (
    .Clk         (Clk),
    .rst         (rst),
    .en          (en),
    .Inputs      (Inputs),
    .Control_out (Control_out)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Apply one instruction for one edge, then check the output 1ns after the edge.
  task automatic step(input logic r, input logic e, input logic [31:0] instr,
                      input logic [7:0] expected, input string tag);
    rst    = r;
    en     = e;
    Inputs = instr;
    @(posedge Clk);
    #1;
    tests_run++;
    assert (Control_out === expected)
    else begin
      tests_failed++;
      $error("FAIL %s: observed %02h expected %02h", tag, Control_out, expected);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst    = 1'b0;
    en     = 1'b0;
    Inputs = 32'h0;

    // Reset has priority over en, including a status-select instruction
    step(1'b0, 1'b1, 32'h2913bc53, 8'h00, "reset_mul");
    step(1'b0, 1'b1, 32'h4200FEFF, 8'h00, "reset_add_stat");

    // en gating
    step(1'b1, 1'b0, 32'h2913bc53, 8'h00, "en_hold_0");
    step(1'b1, 1'b0, 32'h2913bc53, 8'h00, "en_hold_1");

    // MUL bc*53 = 3CF4, held instruction stays stable
    step(1'b1, 1'b1, 32'h2913bc53, 8'h3C, "mul_hi");
    step(1'b1, 1'b1, 32'h2913bc53, 8'h3C, "mul_hi_held");

    // Held SHR by 1: 1E7A, 0F3D, 079E, 03CF
    step(1'b1, 1'b1, 32'h6a3d45f1, 8'h06, "shr_0");
    step(1'b1, 1'b1, 32'h6a3d45f1, 8'h06, "shr_1");
    step(1'b1, 1'b1, 32'h6a3d45f1, 8'h06, "shr_2");
    step(1'b1, 1'b1, 32'h6a3d45f1, 8'h06, "shr_3");
    step(1'b1, 1'b1, 32'h60000000, 8'hCF, "shr_acc_lo");
    step(1'b1, 1'b1, 32'h61000000, 8'h03, "shr_acc_hi");

    // CLR, MAC, ADD overflow
    step(1'b1, 1'b1, 32'h10000000, 8'h00, "clr");
    step(1'b1, 1'b1, 32'h30001010, 8'h00, "mac_lo");
    step(1'b1, 1'b1, 32'h31000000, 8'h01, "mac_hi");
    step(1'b1, 1'b1, 32'h40000001, 8'h01, "add_lo");
    step(1'b1, 1'b1, 32'h4200FEFF, 8'hA4, "add_ovf_stat");

    // Illegal op sets ILL, acc held; NOP clears ILL, V stays sticky
    step(1'b1, 1'b1, 32'hF2000000, 8'hBF, "illegal");
    step(1'b1, 1'b1, 32'h02000000, 8'hA0, "nop_clears_ill");

    // CLR clears V
    step(1'b1, 1'b1, 32'h12000000, 8'h81, "clr_stat");

    // SUB underflow: 0 - 1 = FFFF, V set
    step(1'b1, 1'b1, 32'h50000001, 8'hFF, "sub_lo");
    step(1'b1, 1'b1, 32'h51000000, 8'hFF, "sub_hi");
    step(1'b1, 1'b1, 32'h52000000, 8'h65, "sub_stat");

    // Logic ops: FFFF&0F0F=0F0F, |F000=FF0F, ^00FF=FFF0
    step(1'b1, 1'b1, 32'h80000F0F, 8'h0F, "and");
    step(1'b1, 1'b1, 32'h9100F000, 8'hFF, "or_hi");
    step(1'b1, 1'b1, 32'hA00000FF, 8'hF0, "xor");

    // SHL by 4: FFF0 -> FF00
    step(1'b1, 1'b1, 32'h70000004, 8'h00, "shl_lo");
    step(1'b1, 1'b1, 32'h71000000, 8'hFF, "shl_hi");

    // sel=11 forces zero
    step(1'b1, 1'b1, 32'h03000000, 8'h00, "sel11");

    // MAC overflow: FE01 + FE01 = 1FC02 -> FC02, V=1, N=1
    step(1'b1, 1'b1, 32'h10000000, 8'h00, "clr2");
    step(1'b1, 1'b1, 32'h3000FFFF, 8'h01, "mac_ff");
    step(1'b1, 1'b1, 32'h3200FFFF, 8'h63, "mac_ovf_stat");
    step(1'b1, 1'b1, 32'h01000000, 8'hFC, "mac_ovf_hi");

    // en=0 holds Control_out and state
    step(1'b1, 1'b0, 32'h12000000, 8'hFC, "en_hold_out");
    step(1'b1, 1'b1, 32'h00000000, 8'h02, "en_hold_acc");

    // Reset mid-stream discards the instruction on that edge
    step(1'b0, 1'b1, 32'h40000001, 8'h00, "mid_reset");
    step(1'b1, 1'b1, 32'h02000000, 8'h80, "after_reset_stat");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

`default_nettype wire
